dio24_led_sched: RTL

Per-LED arbiter and scheduler that shares the board LEDs between several status requesters and drives the control inputs of the LED dimming/blinking block (`leds_in`, `leds_bright`, `leds_blink`, `leds_high`, `leds_inv`). Each requester asks for a 5-bit display pattern on a subset of LEDs. The block grants each LED to the highest-priority requester and enforces a minimum display time, so that short events stay visible. An optional lamp test overrides all LEDs for a fixed time.

---
 rtl/dio24_led_sched.sv | 137 +++++++++++++
 1 files changed

// File: rtl/dio24_led_sched.sv
// dio24_led_sched: per-LED priority arbiter with a minimum display time, feeding the LED dimmer controls.
// The optional lamp-test override is compiled in when LED_SCHED_LAMP_TEST_EN is defined.
module dio24_led_sched #(
    parameter int NUM_LEDS    = 2,
    parameter int NUM_REQ     = 4,
    parameter int HOLD_COUNT  = 2**24,
    parameter int TEST_CYCLES = 2**26,
    localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int HCW = $clog2(HOLD_COUNT + 1)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [NUM_REQ*NUM_LEDS-1:0] req_mask,
    input  logic [NUM_REQ*5-1:0]    req_pat,
    input  logic                    lamp_test,
    output logic [NUM_LEDS-1:0]     leds_in,
    output logic [NUM_LEDS-1:0]     leds_bright,
    output logic [NUM_LEDS-1:0]     leds_blink,
    output logic [NUM_LEDS-1:0]     leds_high,
    output logic [NUM_LEDS-1:0]     leds_inv,
    output logic [NUM_LEDS-1:0]     grant_valid,
    output logic [NUM_LEDS*IDW-1:0] grant_id,
    output logic                    test_active,
    output logic [2*NUM_LEDS-1:0]   fsm_state
);

    // Requests are level-held: a requester is served while req_valid and its mask bit are high;
    // there is no ready/acknowledge, ownership is reported only through grant_valid/grant_id.
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_HOLD = 2'd1, S_FOLLOW = 2'd2} state_t;

    logic [NUM_LEDS-1:0] pat_on, pat_bright, pat_blink, pat_high, pat_inv;

    for (genvar k = 0; k < NUM_LEDS; k++) begin : g_led
        logic           cand_valid;
        logic [IDW-1:0] cand_id;
        logic [4:0]     cand_pat;
        logic           preempt, owner_live, hold_busy, do_grant;
        state_t         state_q;
        logic [IDW-1:0] owner_q;
        logic [HCW-1:0] hcnt_q;
        logic [4:0]     pat_q;

        always_comb begin
            cand_valid = 1'b0;
            cand_id    = '0;
            cand_pat   = '0;
            for (int r = NUM_REQ - 1; r >= 0; r--) begin
                if (req_valid[r] && req_mask[r*NUM_LEDS + k]) begin
                    cand_valid = 1'b1;
                    cand_id    = IDW'(r);
                    cand_pat   = req_pat[r*5 +: 5];
                end
            end
        end

        assign preempt    = cand_valid && (cand_id < owner_q);
        assign owner_live = cand_valid && (cand_id == owner_q);
        assign hold_busy  = (state_q == S_HOLD) && (hcnt_q != '0);
        // When the hold expires the FOLLOW decision is taken on the same edge, so the
        // display lasts exactly HOLD_COUNT cycles before a non-preemptive change.
        assign do_grant   = cand_valid &&
                            ((state_q == S_IDLE) || preempt || (!hold_busy && !owner_live));

        always_ff @(posedge clk) begin
            if (reset) begin
                state_q <= S_IDLE;
                owner_q <= '0;
                hcnt_q  <= '0;
                pat_q   <= '0;
            end else if (do_grant) begin
                state_q <= S_HOLD;
                owner_q <= cand_id;
                pat_q   <= cand_pat;
                hcnt_q  <= HCW'(HOLD_COUNT - 1);
            end else if (state_q == S_IDLE) begin
                pat_q   <= '0;
            end else if (hold_busy) begin
                hcnt_q  <= hcnt_q - HCW'(1);
                if (owner_live) pat_q <= cand_pat;
            end else if (owner_live) begin
                state_q <= S_FOLLOW;
                pat_q   <= cand_pat;
            end else begin
                state_q <= S_IDLE;
                owner_q <= '0;
                pat_q   <= '0;
            end
        end

        assign pat_on[k]             = pat_q[4];
        assign pat_bright[k]         = pat_q[3];
        assign pat_blink[k]          = pat_q[2];
        assign pat_high[k]           = pat_q[1];
        assign pat_inv[k]            = pat_q[0];
        assign grant_valid[k]        = (state_q != S_IDLE);
        assign grant_id[k*IDW +: IDW] = owner_q;
        assign fsm_state[2*k +: 2]   = state_q;
    end

`ifdef LED_SCHED_LAMP_TEST_EN
    localparam int TCW = $clog2(TEST_CYCLES + 1);
    logic           lt_q;
    logic           test_q;
    logic [TCW-1:0] tcnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            lt_q   <= 1'b0;
            test_q <= 1'b0;
            tcnt_q <= '0;
        end else begin
            lt_q <= lamp_test;
            if (lamp_test && !lt_q) begin
                test_q <= 1'b1;
                tcnt_q <= TCW'(TEST_CYCLES - 1);
            end else if (test_q) begin
                if (tcnt_q == '0) test_q <= 1'b0;
                else              tcnt_q <= tcnt_q - TCW'(1);
            end
        end
    end

    assign test_active = test_q;
`else
    logic lamp_test_unused;
    assign lamp_test_unused = lamp_test;
    assign test_active      = 1'b0;
`endif

    assign leds_in     = test_active ? '1 : pat_on;
    assign leds_bright = test_active ? '1 : pat_bright;
    assign leds_high   = test_active ? '1 : pat_high;
    assign leds_blink  = test_active ? '0 : pat_blink;
    assign leds_inv    = test_active ? '0 : pat_inv;

endmodule
